// File: rtl/mem_cycle_pkg.sv
// rtl/mem_cycle_pkg.sv - shared types and defaults for the SRAM cycle arbiter
// Purpose: FSM state encoding, read/write grant type and parameter defaults.
// Ports: none (package).
package mem_cycle_pkg;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int BURST_W_DEF     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ACCESS,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_cycle_arbiter_if.sv
// rtl/mem_cycle_arbiter_if.sv - request/strobe bundle between requester and arbiter
// Purpose: groups the request inputs and SRAM strobe / status outputs.
// Ports (master drives): read, write, burst_len.
// Ports (slave drives):  latch, count, not_ce, not_oe, not_we, reading, writing, busy, done.
interface mem_cycle_arbiter_if
  import mem_cycle_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF
);

  logic               read;
  logic               write;
  logic [BURST_W-1:0] burst_len;
  logic               latch;
  logic               count;
  logic               not_ce;
  logic               not_oe;
  logic               not_we;
  logic               reading;
  logic               writing;
  logic               busy;
  logic               done;

  modport master (
    output read, write, burst_len,
    input  latch, count, not_ce, not_oe, not_we, reading, writing, busy, done
  );

  modport slave (
    input  read, write, burst_len,
    output latch, count, not_ce, not_oe, not_we, reading, writing, busy, done
  );

endinterface

// File: rtl/mem_cycle_arbiter_burst_counter.sv
// rtl/mem_cycle_arbiter_burst_counter.sv - loadable down-counter with zero flag
// Purpose: holds a wait or remaining-word count; load wins over decrement,
//          decrement saturates at zero.
// Ports: clk, reset (async, active high), load, load_val, dec -> zero.
module burst_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero = (value_q == '0);

endmodule

// File: rtl/mem_cycle_arbiter.sv
// rtl/mem_cycle_arbiter.sv - read/write arbiter and SRAM burst cycle sequencer
// Purpose: grants one read or write burst at a time (alternating on ties) and
//          sequences LATCH -> (ACCESS -> NEXT) x words -> DONE with registered strobes.
// Ports: clk, reset (async, active high), bus (slave modport of mem_cycle_arbiter_if).
module mem_cycle_arbiter
  import mem_cycle_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int BURST_W     = BURST_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_cycle_arbiter_if.slave     bus
);

  // ACCESS lasts WAIT_CYCLES clocks: the counter is loaded with WAIT_CYCLES-1
  // on entry and ACCESS exits on the cycle it reads zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t state_q, state_d;
  gnt_t   last_q, last_d;
  gnt_t   cur_q, cur_d;
  gnt_t   gnt;

  logic rem_load, rem_dec, rem_zero;
  logic wait_load, wait_dec, wait_zero;

  logic latch_q, latch_d;
  logic count_q, count_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic reading_q, reading_d;
  logic writing_q, writing_d;
  logic not_ce_q, not_ce_d;
  logic not_oe_q, not_oe_d;
  logic not_we_q, not_we_d;

  burst_counter #(.W(BURST_W)) u_rem_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rem_load),
    .load_val (bus.burst_len),
    .dec      (rem_dec),
    .zero     (rem_zero)
  );

  burst_counter #(.W(4)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // Next-state, grant and counter control.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_d     = cur_q;
    gnt       = GNT_READ;
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.read || bus.write) begin
          if (bus.read && bus.write) begin
            gnt = (last_q == GNT_WRITE) ? GNT_READ : GNT_WRITE;
          end else begin
            gnt = bus.read ? GNT_READ : GNT_WRITE;
          end
          cur_d    = gnt;
          last_d   = gnt;
          // burst_len is captured at the grant edge so later changes are ignored.
          rem_load = 1'b1;
          state_d  = ST_LATCH;
        end
      end
      ST_LATCH: begin
        wait_load = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (wait_zero) begin
          state_d = ST_NEXT;
        end else begin
          wait_dec = 1'b1;
        end
      end
      ST_NEXT: begin
        if (rem_zero) begin
          state_d = ST_DONE;
        end else begin
          rem_dec   = 1'b1;
          wait_load = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // changes exactly on the edge that enters its state.
  always_comb begin
    latch_d   = (state_d == ST_LATCH);
    count_d   = (state_d == ST_NEXT);
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
    reading_d = busy_d && (cur_d == GNT_READ);
    writing_d = busy_d && (cur_d == GNT_WRITE);
    not_ce_d  = !((state_d == ST_LATCH) || (state_d == ST_ACCESS) || (state_d == ST_NEXT));
    not_oe_d  = !((state_d == ST_ACCESS) && (cur_d == GNT_READ));
    not_we_d  = !((state_d == ST_ACCESS) && (cur_d == GNT_WRITE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= GNT_WRITE;
      cur_q     <= GNT_READ;
      latch_q   <= 1'b0;
      count_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      reading_q <= 1'b0;
      writing_q <= 1'b0;
      not_ce_q  <= 1'b1;
      not_oe_q  <= 1'b1;
      not_we_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      latch_q   <= latch_d;
      count_q   <= count_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      reading_q <= reading_d;
      writing_q <= writing_d;
      not_ce_q  <= not_ce_d;
      not_oe_q  <= not_oe_d;
      not_we_q  <= not_we_d;
    end
  end

  assign bus.latch   = latch_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.reading = reading_q;
  assign bus.writing = writing_q;
  assign bus.not_ce  = not_ce_q;
  assign bus.not_oe  = not_oe_q;
  assign bus.not_we  = not_we_q;

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// tb/tb_mem_cycle_arbiter.sv - scoreboard bench for the SRAM cycle arbiter
module tb_mem_cycle_arbiter;

  localparam int W  = 2;
  localparam int BW = 4;
  localparam int N_RANDOM_CYCLES = 1500;

  typedef struct {
    bit is_write;
    int blen;
    int issue_cyc;
  } exp_t;

  typedef struct {
    bit rd;
    bit wr;
    int blen;
  } req_t;

  logic clk;
  logic reset;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;
  bit   last_w;
  bit   in_txn;
  exp_t exp_q[$];
  req_t dir_q[$];

  mem_cycle_arbiter_if #(.BURST_W(BW)) bus ();

  mem_cycle_arbiter #(
    .WAIT_CYCLES (W),
    .BURST_W     (BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int out_vec();
    return {23'd0, bus.latch, bus.count, bus.done, bus.busy, bus.reading,
            bus.writing, bus.not_ce, bus.not_oe, bus.not_we};
  endfunction

  // Reference arbitration: ties go opposite to the last served type.
  task automatic issue(input bit rd, input bit wr, input int blen);
    exp_t e;
    bus.read      = rd;
    bus.write     = wr;
    bus.burst_len = BW'(blen);
    if (rd || wr) begin
      e.is_write  = (rd && wr) ? !last_w : wr;
      e.blen      = blen;
      e.issue_cyc = cyc;
      last_w      = e.is_write;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.busy, 0);
  endtask

  // Monitor: measures each transaction from latch to done and scores it.
  initial begin : monitor
    int  n_cyc, n_cnt, n_oe, n_we, n_latch, n_rd, n_wr, n_notbusy;
    bit  prev_done;
    exp_t e;
    int  len;
    in_txn    = 0;
    prev_done = 0;
    n_cyc = 0; n_cnt = 0; n_oe = 0; n_we = 0;
    n_latch = 0; n_rd = 0; n_wr = 0; n_notbusy = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn    = 0;
        prev_done = 0;
      end else begin
        check("strobe_exclusive",
              int'((!bus.not_oe && !bus.not_we) ||
                   ((!bus.not_oe || !bus.not_we) && bus.not_ce)), 0);
        if (prev_done) begin
          check("done_one_cycle", int'({bus.done, bus.busy}), 0);
        end
        prev_done = 0;
        if (bus.latch) begin
          check("latch_after_done", int'(in_txn), 0);
          check("grant_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            check("grant_latency", cyc, exp_q[0].issue_cyc + 1);
          end
          in_txn = 1;
          n_cyc = 0; n_cnt = 0; n_oe = 0; n_we = 0;
          n_latch = 0; n_rd = 0; n_wr = 0; n_notbusy = 0;
        end
        if (bus.done) begin
          check("done_in_txn", int'(in_txn), 1);
        end
        if (in_txn) begin
          n_cyc++;
          n_cnt     += int'(bus.count);
          n_oe      += int'(!bus.not_oe);
          n_we      += int'(!bus.not_we);
          n_latch   += int'(bus.latch);
          n_rd      += int'(bus.reading);
          n_wr      += int'(bus.writing);
          n_notbusy += int'(!bus.busy);
          if (bus.done) begin
            in_txn    = 0;
            prev_done = 1;
            if (exp_q.size() > 0) begin
              e   = exp_q.pop_front();
              len = 2 + (e.blen + 1) * (W + 1);
              check("txn_length", n_cyc, len);
              check("count_pulses", n_cnt, e.blen + 1);
              check("latch_cycles", n_latch, 1);
              check("busy_through", n_notbusy, 0);
              check("oe_low_cycles", n_oe, e.is_write ? 0 : (e.blen + 1) * W);
              check("we_low_cycles", n_we, e.is_write ? (e.blen + 1) * W : 0);
              check("reading_cycles", n_rd, e.is_write ? 0 : len);
              check("writing_cycles", n_wr, e.is_write ? len : 0);
            end
          end
        end
      end
    end
  end

  // Driver: requests only when idle; random noise on the inputs while busy.
  initial begin : driver
    req_t r;
    chk_cnt       = 0;
    pass_cnt      = 0;
    last_w        = 1;
    reset         = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.burst_len = '0;

    #3;
    check("reset_outputs", out_vec(), 9'b000000111);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    r = '{1, 0, 0};  dir_q.push_back(r);
    r = '{0, 1, 3};  dir_q.push_back(r);
    r = '{1, 1, 2};  dir_q.push_back(r);
    r = '{1, 1, 1};  dir_q.push_back(r);
    r = '{1, 1, 0};  dir_q.push_back(r);

    while (dir_q.size() > 0) begin
      @(negedge clk);
      if (!bus.busy) begin
        r = dir_q.pop_front();
        issue(r.rd, r.wr, r.blen);
      end else begin
        bus.read      = 1'($urandom_range(0, 1));
        bus.write     = 1'($urandom_range(0, 1));
        bus.burst_len = BW'($urandom_range(0, 15));
      end
    end

    // Abandon a 4-word read in its first ACCESS cycle.
    @(negedge clk);
    wait_idle("idle_before_reset");
    issue(1, 0, 3);
    @(posedge clk);
    @(negedge clk);
    bus.read = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midburst_reset_outputs", out_vec(), 9'b000000111);
    void'(exp_q.pop_back());
    last_w = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue(1, 0, 1);

    for (int i = 0; i < N_RANDOM_CYCLES; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        if ($urandom_range(0, 3) == 0) begin
          issue(0, 0, int'($urandom_range(0, 15)));
        end else begin
          case ($urandom_range(0, 2))
            0:       issue(1, 0, int'($urandom_range(0, 15)));
            1:       issue(0, 1, int'($urandom_range(0, 15)));
            default: issue(1, 1, int'($urandom_range(0, 15)));
          endcase
        end
      end else begin
        bus.read      = 1'($urandom_range(0, 1));
        bus.write     = 1'($urandom_range(0, 1));
        bus.burst_len = BW'($urandom_range(0, 15));
      end
    end

    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    wait_idle("drain_idle");
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("no_open_txn", int'(in_txn), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
